// File: rtl/psola_frame_sequencer_if.sv
// Bus bundle between the PSOLA frame sequencer and its environment
// (pitch detector, psola core, accumulation BRAM, playback sink).
// Optional macro: PSOLA_SEQ_TIMEOUT_EN adds timeout_out.
interface psola_seq_if;
  logic        frame_valid_in;
  logic        frame_ready_out;
  logic        tau_valid_in;
  logic [10:0] tau_in;
  logic        psola_tau_valid_out;
  logic [10:0] psola_tau_out;
  logic        window_len_valid_in;
  logic [11:0] window_len_in;
  logic [11:0] psola_waddr_in;
  logic [31:0] psola_wval_in;
  logic        psola_we_in;
  logic [11:0] acc_raddr_out;
  logic [31:0] acc_rdata_in;
  logic [11:0] acc_waddr_out;
  logic [31:0] acc_wdata_out;
  logic        acc_we_out;
  logic [11:0] psola_raddr_in;
  logic [15:0] sample_out;
  logic        sample_valid_out;
  logic        sample_ready_in;
  logic        busy_out;
  logic [7:0]  drop_count_out;
  logic [2:0]  state_out;
`ifdef PSOLA_SEQ_TIMEOUT_EN
  logic        timeout_out;
`endif

  // sequencer side
  modport master (
`ifdef PSOLA_SEQ_TIMEOUT_EN
    output timeout_out,
`endif
    output frame_ready_out, psola_tau_valid_out, psola_tau_out,
    output acc_raddr_out, acc_waddr_out, acc_wdata_out, acc_we_out,
    output sample_out, sample_valid_out, busy_out, drop_count_out, state_out,
    input  frame_valid_in, tau_valid_in, tau_in, window_len_valid_in, window_len_in,
    input  psola_waddr_in, psola_wval_in, psola_we_in, psola_raddr_in,
    input  acc_rdata_in, sample_ready_in
  );

  // environment side
  modport slave (
`ifdef PSOLA_SEQ_TIMEOUT_EN
    input  timeout_out,
`endif
    input  frame_ready_out, psola_tau_valid_out, psola_tau_out,
    input  acc_raddr_out, acc_waddr_out, acc_wdata_out, acc_we_out,
    input  sample_out, sample_valid_out, busy_out, drop_count_out, state_out,
    output frame_valid_in, tau_valid_in, tau_in, window_len_valid_in, window_len_in,
    output psola_waddr_in, psola_wval_in, psola_we_in, psola_raddr_in,
    output acc_rdata_in, sample_ready_in
  );
endinterface

// File: rtl/psola_frame_sequencer.sv
// PSOLA frame sequencer: clears the accumulation buffer, hands each analysis
// frame to the psola core, then drains the accumulated output through a small
// skid FIFO while zeroing each word behind the read.
// Optional macro: PSOLA_SEQ_TIMEOUT_EN adds a RUN-state watchdog and the
// timeout_out port. FIFO_DEPTH must be at least 3.
module psola_frame_sequencer #(
  parameter int MAX_EXTENDED   = 2200,
  parameter int FRACTION_BITS  = 11,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic         clk_in,
  input logic         rst_in,
  psola_seq_if.master bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_CLEAR    = 3'd0,
    S_IDLE     = 3'd1,
    S_WAIT_TAU = 3'd2,
    S_RUN      = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t      state;
  logic [11:0] clr_addr, len, iss_addr, acc_cnt;
  logic [10:0] tau_q;
  logic        tau_vld_q;
  logic [7:0]  drop_cnt;

  // read pipeline: [1] = data one cycle away, [2] = data on acc_rdata_in now
  logic [2:1]        rd_vld_pipe;
  logic [2:1][11:0]  rd_addr_pipe;
  logic              rd_issue;

  logic [FIFO_DEPTH-1:0][15:0] fifo_mem;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       pend;
  logic              push, pop;
  logic [31:0]       rdata_hi;
  logic [15:0]       sample_cvt;

`ifdef PSOLA_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_fire, timed_out;
  assign wd_fire = (state == S_RUN) && !bus.window_len_valid_in &&
                   (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign bus.timeout_out = wd_fire;
`endif

  // occupancy plus outstanding reads bounds how far the drain may run ahead
  assign pend     = {1'b0, fifo_cnt} + {{CW{1'b0}}, rd_vld_pipe[1]} + {{CW{1'b0}}, rd_vld_pipe[2]};
  assign rd_issue = (state == S_DRAIN) && (iss_addr < len) && (pend < (CW+1)'(FIFO_DEPTH));
  assign push     = rd_vld_pipe[2];
  assign pop      = bus.sample_valid_out && bus.sample_ready_in;

  // fixed-point to 16-bit sample, saturating on any integer overflow bit
  assign rdata_hi   = bus.acc_rdata_in >> (FRACTION_BITS + 16);
  assign sample_cvt = (|rdata_hi) ? 16'hFFFF : bus.acc_rdata_in[FRACTION_BITS +: 16];

  assign bus.frame_ready_out     = (state == S_IDLE);
  assign bus.busy_out            = (state != S_IDLE);
  assign bus.state_out           = state;
  assign bus.psola_tau_valid_out = tau_vld_q;
  assign bus.psola_tau_out       = tau_q;
  assign bus.drop_count_out      = drop_cnt;
  assign bus.sample_valid_out    = (fifo_cnt != '0);
  assign bus.sample_out          = fifo_mem[rd_ptr];

  // accumulation port mux: psola owns it in RUN, sequencer in CLEAR/DRAIN
  always_comb begin
    bus.acc_raddr_out = '0;
    bus.acc_waddr_out = '0;
    bus.acc_wdata_out = '0;
    bus.acc_we_out    = 1'b0;
    case (state)
      S_CLEAR: begin
        bus.acc_we_out    = !rst_in;
        bus.acc_waddr_out = clr_addr;
      end
      S_RUN: begin
        bus.acc_raddr_out = bus.psola_raddr_in;
        bus.acc_waddr_out = bus.psola_waddr_in;
        bus.acc_wdata_out = bus.psola_wval_in;
        bus.acc_we_out    = bus.psola_we_in;
      end
      S_DRAIN: begin
        if (rd_issue) bus.acc_raddr_out = iss_addr;
        if (push) begin
          bus.acc_we_out    = 1'b1;
          bus.acc_waddr_out = rd_addr_pipe[2];
        end
      end
      default: ;
    endcase
  end

  // main sequencing FSM, drop counter and watchdog
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_CLEAR;
      clr_addr  <= '0;
      len       <= '0;
      iss_addr  <= '0;
      acc_cnt   <= '0;
      tau_q     <= '0;
      tau_vld_q <= 1'b0;
      drop_cnt  <= '0;
`ifdef PSOLA_SEQ_TIMEOUT_EN
      wd_cnt    <= '0;
      timed_out <= 1'b0;
`endif
    end else begin
      tau_vld_q <= 1'b0;
      if (bus.frame_valid_in && state != S_IDLE && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      case (state)
        S_CLEAR: begin
          clr_addr <= clr_addr + 12'd1;
          if (clr_addr == 12'(MAX_EXTENDED - 1)) begin
            clr_addr <= '0;
            state    <= S_IDLE;
          end
        end
        S_IDLE: if (bus.frame_valid_in) state <= S_WAIT_TAU;
        S_WAIT_TAU: if (bus.tau_valid_in) begin
          tau_q     <= bus.tau_in;
          tau_vld_q <= 1'b1;
          state     <= S_RUN;
`ifdef PSOLA_SEQ_TIMEOUT_EN
          wd_cnt    <= '0;
`endif
        end
        S_RUN: begin
          if (bus.window_len_valid_in) begin
            len      <= bus.window_len_in;
            iss_addr <= '0;
            acc_cnt  <= '0;
            state    <= S_DRAIN;
          end
`ifdef PSOLA_SEQ_TIMEOUT_EN
          else if (wd_fire) begin
            len       <= '0;
            iss_addr  <= '0;
            acc_cnt   <= '0;
            timed_out <= 1'b1;
            state     <= S_DRAIN;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
`endif
        end
        S_DRAIN: begin
          if (rd_issue) iss_addr <= iss_addr + 12'd1;
          if (pop)      acc_cnt  <= acc_cnt + 12'd1;
          if (acc_cnt == len && fifo_cnt == '0) begin
`ifdef PSOLA_SEQ_TIMEOUT_EN
            // psola may have left partial sums behind: scrub before reuse
            state     <= timed_out ? S_CLEAR : S_IDLE;
            timed_out <= 1'b0;
`else
            state <= S_IDLE;
`endif
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // read-return tracking and skid FIFO bookkeeping
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_vld_pipe  <= '0;
      rd_addr_pipe <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
    end else begin
      rd_vld_pipe[1]  <= rd_issue;
      rd_vld_pipe[2]  <= rd_vld_pipe[1];
      rd_addr_pipe[1] <= iss_addr;
      rd_addr_pipe[2] <= rd_addr_pipe[1];
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage, no reset needed behind the count
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= sample_cvt;
  end
endmodule
